count_sched: RTL and testbench

Two-requester scheduler that shares a single loadable down-counter as a delay timer. Each requester asks for an N-cycle interval; the scheduler arbitrates round-robin, loads the counter with that requester's length, sequences the count, and pulses a per-requester done when the interval expires. It sits beside the lab counter datapath as its sequencing and arbitration front end.

---
 rtl/count_sched_pkg.sv | 19 +
 rtl/down_counter.sv | 23 ++
 rtl/count_sched.sv | 97 +++++++++
 tb/tb_count_sched.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/count_sched_pkg.sv
// Shared types and helpers for the count_sched scheduler slice.
package count_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int unsigned NUM_REQ = 2;

    function automatic logic [NUM_REQ-1:0] onehot(input logic idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/down_counter.sv
// Loadable down-counter that saturates at zero instead of wrapping.
module down_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    output logic [WIDTH-1:0] out
);

    always_ff @(posedge clk) begin
        if (reset) begin
            out <= '0;
        end else if (load) begin
            out <= d;
        end else if (en && (out != '0)) begin
            out <= out - 1'b1;
        end
    end

endmodule

// File: rtl/count_sched.sv
// Round-robin two-requester scheduler sharing one down-counter as a delay timer.
module count_sched
    import count_sched_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [WIDTH-1:0]   len0,
    input  logic [WIDTH-1:0]   len1,
    input  logic               hold,
    output logic [NUM_REQ-1:0] grant,
    output logic [NUM_REQ-1:0] done,
    output logic               busy,
    output logic               owner,
    output logic [WIDTH-1:0]   cnt
);

    state_t             state, state_next;
    logic               last;
    logic               win;
    logic [WIDTH-1:0]   len_win;
    logic               take;
    logic               load;
    logic               en;
    logic [NUM_REQ-1:0] grant_next;

    // A tie goes to whoever did not win last time; a lone requester always wins.
    always_comb begin
        win     = (req == 2'b11) ? ~last : req[1];
        len_win = win ? len1 : len0;
    end

    always_comb begin
        state_next = state;
        take       = 1'b0;
        load       = 1'b0;
        en         = 1'b0;
        grant_next = '0;
        unique case (state)
            IDLE: begin
                if (req != '0) begin
                    take       = 1'b1;
                    load       = 1'b1;
                    grant_next = onehot(win);
                    state_next = (len_win != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (!hold) begin
                    en = 1'b1;
                    if (cnt == WIDTH'(1)) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            last  <= 1'b1;
            owner <= 1'b0;
            grant <= '0;
        end else begin
            state <= state_next;
            grant <= grant_next;
            if (take) begin
                owner <= win;
                last  <= win;
            end
        end
    end

    assign done = (state == DONE) ? onehot(owner) : '0;
    assign busy = (state != IDLE);

    down_counter #(
        .WIDTH(WIDTH)
    ) u_counter (
        .clk  (clk),
        .reset(reset),
        .load (load),
        .d    (len_win),
        .en   (en),
        .out  (cnt)
    );

endmodule

// File: tb/tb_count_sched.sv
// Self-checking bench for count_sched: directed scenarios plus randomized traffic vs a transaction-level model.
module tb_count_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic [7:0] len0, len1;
    logic       hold;
    logic [1:0] grant, done;
    logic       busy, owner;
    logic [7:0] cnt;

    count_sched #(.WIDTH(8)) dut (
        .clk  (clk),
        .reset(reset),
        .req  (req),
        .len0 (len0),
        .len1 (len1),
        .hold (hold),
        .grant(grant),
        .done (done),
        .busy (busy),
        .owner(owner),
        .cnt  (cnt)
    );

    always #5 clk = ~clk;

    int unsigned passed = 0;
    int unsigned total  = 0;
    int unsigned cyc    = 0;

    // Transaction-level expectation: an interval in flight, its remaining count, and arbitration history.
    logic [1:0] m_grant, m_done;
    logic       m_busy, m_owner, m_last;
    int         m_cnt;

    int         gcyc [2];
    int         dcyc [2];
    int         ndone[2];
    logic       gq[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic model_step(input logic r, input logic [1:0] rq, input logic [7:0] l0,
                              input logic [7:0] l1, input logic hd);
        logic w;
        int   len;
        if (r) begin
            m_busy = 1'b0; m_grant = 2'b00; m_done = 2'b00;
            m_owner = 1'b0; m_last = 1'b1; m_cnt = 0;
        end else if (m_done != 2'b00) begin
            // the expiry cycle is always followed by an idle cycle
            m_done = 2'b00; m_grant = 2'b00; m_busy = 1'b0;
        end else if (m_busy) begin
            m_grant = 2'b00;
            if (!hd) m_cnt = m_cnt - 1;
            if (m_cnt == 0) m_done = 2'(1) << m_owner;
        end else if (rq != 2'b00) begin
            w       = (rq == 2'b11) ? !m_last : rq[1];
            len     = w ? int'(l1) : int'(l0);
            m_grant = 2'(1) << w;
            m_owner = w;
            m_last  = w;
            m_cnt   = len;
            m_busy  = 1'b1;
            m_done  = (len == 0) ? m_grant : 2'b00;
        end else begin
            m_grant = 2'b00;
        end
    endtask

    task automatic tick(input logic r, input logic [1:0] rq, input logic [7:0] l0,
                        input logic [7:0] l1, input logic hd);
        reset = r; req = rq; len0 = l0; len1 = l1; hold = hd;
        @(posedge clk);
        model_step(r, rq, l0, l1, hd);
        cyc++;
        @(negedge clk);
        check("grant", 32'(grant), 32'(m_grant));
        check("done",  32'(done),  32'(m_done));
        check("busy",  32'(busy),  32'(m_busy));
        check("owner", 32'(owner), 32'(m_owner));
        check("cnt",   32'(cnt),   32'(m_cnt));
        for (int i = 0; i < 2; i++) begin
            if (grant[i]) gcyc[i] = int'(cyc);
            if (done[i]) begin
                dcyc[i] = int'(cyc);
                ndone[i]++;
            end
        end
        if (grant != 2'b00) gq.push_back(grant[1]);
    endtask

    initial begin
        logic [1:0] pend;
        int         nd0;
        logic       r;
        logic [1:0] rq;
        logic [7:0] a, b;

        reset = 1'b1; req = 2'b00; len0 = '0; len1 = '0; hold = 1'b0;
        gcyc = '{-1, -1}; dcyc = '{-1, -1}; ndone = '{0, 0};

        // reset values
        tick(1, 2'b00, 0, 0, 0);
        tick(1, 2'b00, 0, 0, 0);
        tick(0, 2'b00, 0, 0, 0);

        // single request, len 3: done three cycles after the grant
        tick(0, 2'b01, 3, 0, 0);
        for (int k = 0; k < 6; k++) tick(0, 2'b00, 0, 0, 0);
        check("t1_latency", 32'(dcyc[0] - gcyc[0]), 32'd3);

        // simultaneous requests from reset: requester 0 first, then 1
        tick(1, 2'b00, 0, 0, 0);
        pend = 2'b11;
        for (int k = 0; k < 20; k++) begin
            tick(0, pend, 2, 5, 0);
            pend = pend & ~grant;
        end
        check("t2_first_is_0", 32'(gcyc[0] < gcyc[1]), 32'd1);
        check("t2_lat0", 32'(dcyc[0] - gcyc[0]), 32'd2);
        check("t2_lat1", 32'(dcyc[1] - gcyc[1]), 32'd5);
        check("t2_gap",  32'(gcyc[1] - dcyc[0]), 32'd2);

        // zero length: grant and done together
        tick(0, 2'b01, 0, 0, 0);
        tick(0, 2'b00, 0, 0, 0);
        tick(0, 2'b00, 0, 0, 0);
        check("t3_same_cycle", 32'(dcyc[0] - gcyc[0]), 32'd0);

        // hold two cycles mid-run adds two cycles
        tick(0, 2'b10, 0, 4, 0);
        tick(0, 2'b00, 0, 0, 0);
        tick(0, 2'b00, 0, 0, 1);
        tick(0, 2'b00, 0, 0, 1);
        for (int k = 0; k < 6; k++) tick(0, 2'b00, 0, 0, 0);
        check("t4_hold_latency", 32'(dcyc[1] - gcyc[1]), 32'd6);

        // reset during a long run: no done, then re-granted
        tick(1, 2'b00, 0, 0, 0);
        tick(0, 2'b01, 10, 0, 0);
        for (int k = 0; k < 3; k++) tick(0, 2'b01, 10, 0, 0);
        nd0 = ndone[0];
        tick(1, 2'b01, 10, 0, 0);
        tick(0, 2'b01, 10, 0, 0);
        check("t5_regrant", 32'(gcyc[0]), 32'(cyc));
        check("t5_no_done", 32'(ndone[0]), 32'(nd0));
        for (int k = 0; k < 14; k++) tick(0, 2'b00, 0, 0, 0);

        // both held high: grants alternate 0,1,0,1
        tick(1, 2'b00, 0, 0, 0);
        gq.delete();
        for (int k = 0; k < 14; k++) tick(0, 2'b11, 1, 1, 0);
        check("t6_count", 32'(gq.size() >= 4), 32'd1);
        for (int i = 0; i < 4; i++)
            check("t6_order", 32'((i < gq.size()) ? gq[i] : 1'bx), 32'(i % 2));
        for (int k = 0; k < 4; k++) tick(0, 2'b00, 0, 0, 0);

        // randomized traffic, including extreme lengths and stray resets
        for (int k = 0; k < 800; k++) begin
            r  = ($urandom_range(0, 59) == 0);
            rq = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(0, 6));
            b  = ($urandom_range(0, 9) == 0) ? 8'd0   : 8'($urandom_range(0, 6));
            tick(r, rq, a, b, 1'($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
